pattern_matcher: RTL and testbench

- Parametrised successor to the fixed three-character grammar checker: validates a byte stream against a runtime-programmable pattern of 1..MAX_LEN symbols.
- Two modes: anchored (whole-sequence accept/reject with restart) and streaming (overlapping search anywhere in the stream).
- Sits between the UART receive path and the control/status logic.
- Provides level accept/reject flags, a one-cycle match pulse and a saturating match counter.

---
 rtl/pattern_matcher_if.sv | 50 +++++
 rtl/pattern_matcher.sv | 226 ++++++++++++++++++++++
 tb/tb_pattern_matcher.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_matcher_if.sv
// -----------------------------------------------------------------------------
// pattern_matcher_if
// Groups the symbol stream, configuration bus, counter clear and status
// outputs of pattern_matcher. clk and rst stay plain module ports.
//   slave  : the matcher side (takes stream/config, drives status)
//   master : the producer/consumer side (drives stream/config, reads status)
// Signals:
//   data_in/data_valid          received symbol and its qualifier
//   cfg_wr/cfg_ctrl             config strobe; 0 = pattern symbol, 1 = control
//   cfg_idx/cfg_data            pattern symbol write
//   cfg_len/cfg_mode            control write (length, 0 anchored / 1 streaming)
//   clr_count                   clear the match counter
//   accept/reject/match_pulse   match status
//   match_count/enabled         saturating match count, pattern-length valid
// -----------------------------------------------------------------------------
interface pattern_matcher_if #(
   parameter int DATA_W  = 8,
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 16
);
   localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int LEN_W = $clog2(MAX_LEN + 1);

   logic [DATA_W-1:0] data_in;
   logic              data_valid;
   logic              cfg_wr;
   logic              cfg_ctrl;
   logic [IDX_W-1:0]  cfg_idx;
   logic [DATA_W-1:0] cfg_data;
   logic [LEN_W-1:0]  cfg_len;
   logic              cfg_mode;
   logic              clr_count;
   logic              accept;
   logic              reject;
   logic              match_pulse;
   logic [CNT_W-1:0]  match_count;
   logic              enabled;

   modport slave (
      input  data_in, data_valid, cfg_wr, cfg_ctrl, cfg_idx, cfg_data,
             cfg_len, cfg_mode, clr_count,
      output accept, reject, match_pulse, match_count, enabled
   );

   modport master (
      output data_in, data_valid, cfg_wr, cfg_ctrl, cfg_idx, cfg_data,
             cfg_len, cfg_mode, clr_count,
      input  accept, reject, match_pulse, match_count, enabled
   );
endinterface

// File: rtl/pattern_matcher.sv
// -----------------------------------------------------------------------------
// pattern_matcher
// Checks a byte stream against a runtime-programmable pattern of 1..MAX_LEN
// symbols. Anchored mode accepts/rejects whole sequences and restarts after
// each verdict; streaming mode reports every (overlapping) occurrence.
// Ports:
//   clk  system clock
//   rst  synchronous reset, active high
//   bus  pattern_matcher_if.slave (stream, config, counter clear, status)
// All status outputs are registered; a symbol's result appears the cycle
// after its data_valid.
// Build option: define PATTERN_MATCHER_CASE_FOLD_EN (DATA_W = 8) to compare
// ASCII letters case-insensitively; the stored pattern is not modified.
// -----------------------------------------------------------------------------
module pattern_matcher #(
   parameter int DATA_W  = 8,
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 16
) (
   input logic             clk,
   input logic             rst,
   pattern_matcher_if.slave bus
);
   localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int LEN_W = $clog2(MAX_LEN + 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MATCHING = 2'd1,
      ACCEPT   = 2'd2,
      REJECT   = 2'd3
   } state_t;

   logic [DATA_W-1:0] pattern_r [MAX_LEN];
   logic [DATA_W-1:0] win_r     [MAX_LEN];   // index 0 = newest symbol
   logic [DATA_W-1:0] win_s     [MAX_LEN];
   logic [LEN_W-1:0]  len_r;
   logic              mode_r;
   logic              enabled_r;
   state_t            state_r, state_n_s;
   logic [LEN_W-1:0]  pos_r, pos_n_s;
   logic [LEN_W-1:0]  fill_r, fill_n_s, fill_inc_s;
   logic              accept_r, accept_n_s;
   logic              reject_r, reject_n_s;
   logic              pulse_r, pulse_n_s;
   logic [CNT_W-1:0]  count_r;
   logic              shift_s;
   logic              anch_hit_s;
   logic              stream_hit_s;
   logic [IDX_W-1:0]  anch_idx_s;

   // Maps lower-case ASCII onto upper-case when folding is built in.
   function automatic logic [DATA_W-1:0] fold(input logic [DATA_W-1:0] b);
`ifdef PATTERN_MATCHER_CASE_FOLD_EN
      if ((b >= DATA_W'(8'h61)) && (b <= DATA_W'(8'h7A))) begin
         return b - DATA_W'(8'h20);
      end else begin
         return b;
      end
`else
      return b;
`endif
   endfunction

   function automatic logic sym_eq(input logic [DATA_W-1:0] a,
                                   input logic [DATA_W-1:0] b);
      return fold(a) == fold(b);
   endfunction

   // Candidate window with the incoming symbol shifted in at the newest end.
   always_comb begin
      win_s[0] = bus.data_in;
      for (int i = 1; i < MAX_LEN; i++) begin
         win_s[i] = win_r[i-1];
      end
   end

   // Streaming hit: newest len symbols equal pattern[0..len-1] in arrival order.
   always_comb begin
      fill_inc_s   = (fill_r == LEN_W'(MAX_LEN)) ? fill_r : (fill_r + LEN_W'(1));
      stream_hit_s = (fill_inc_s >= len_r);
      for (int i = 0; i < MAX_LEN; i++) begin
         if (i < int'(len_r)) begin
            if (!sym_eq(win_s[i], pattern_r[IDX_W'(int'(len_r) - 1 - i)])) begin
               stream_hit_s = 1'b0;
            end else begin
               stream_hit_s = stream_hit_s;
            end
         end else begin
            stream_hit_s = stream_hit_s;
         end
      end
   end

   // Anchored compare: only MATCHING continues a sequence, every other state starts at 0.
   always_comb begin
      if (state_r == MATCHING) begin
         anch_idx_s = IDX_W'(pos_r);
      end else begin
         anch_idx_s = IDX_W'(0);
      end
      anch_hit_s = sym_eq(bus.data_in, pattern_r[anch_idx_s]);
   end

   // Next-state and next-output logic; configuration writes flush and drop the symbol.
   always_comb begin
      state_n_s  = state_r;
      pos_n_s    = pos_r;
      fill_n_s   = fill_r;
      accept_n_s = accept_r;
      reject_n_s = reject_r;
      pulse_n_s  = 1'b0;
      shift_s    = 1'b0;
      if (bus.cfg_wr) begin
         state_n_s  = IDLE;
         pos_n_s    = LEN_W'(0);
         fill_n_s   = LEN_W'(0);
         accept_n_s = 1'b0;
         reject_n_s = 1'b0;
      end else if (bus.data_valid && enabled_r) begin
         if (mode_r) begin
            shift_s    = 1'b1;
            fill_n_s   = fill_inc_s;
            accept_n_s = stream_hit_s;
            reject_n_s = 1'b0;
            pulse_n_s  = stream_hit_s;
         end else begin
            case (state_r)
               MATCHING: begin
                  if (anch_hit_s && (pos_r == (len_r - LEN_W'(1)))) begin
                     state_n_s  = ACCEPT;
                     pos_n_s    = LEN_W'(0);
                     accept_n_s = 1'b1;
                     reject_n_s = 1'b0;
                     pulse_n_s  = 1'b1;
                  end else if (anch_hit_s) begin
                     pos_n_s = pos_r + LEN_W'(1);
                  end else begin
                     // the failing symbol is not retried as a new start
                     state_n_s  = REJECT;
                     pos_n_s    = LEN_W'(0);
                     accept_n_s = 1'b0;
                     reject_n_s = 1'b1;
                  end
               end
               IDLE, ACCEPT, REJECT: begin
                  if (anch_hit_s && (len_r == LEN_W'(1))) begin
                     state_n_s  = ACCEPT;
                     accept_n_s = 1'b1;
                     reject_n_s = 1'b0;
                     pulse_n_s  = 1'b1;
                  end else if (anch_hit_s) begin
                     state_n_s  = MATCHING;
                     pos_n_s    = LEN_W'(1);
                     accept_n_s = 1'b0;
                     reject_n_s = 1'b0;
                  end else begin
                     state_n_s  = REJECT;
                     pos_n_s    = LEN_W'(0);
                     accept_n_s = 1'b0;
                     reject_n_s = 1'b1;
                  end
               end
               default: begin
                  state_n_s  = IDLE;
                  pos_n_s    = LEN_W'(0);
                  accept_n_s = 1'b0;
                  reject_n_s = 1'b0;
               end
            endcase
         end
      end else begin
         pulse_n_s = 1'b0;
      end
   end

   // State, configuration, window and counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            pattern_r[i] <= '0;
            win_r[i]     <= '0;
         end
         len_r     <= LEN_W'(0);
         mode_r    <= 1'b0;
         enabled_r <= 1'b0;
         state_r   <= IDLE;
         pos_r     <= LEN_W'(0);
         fill_r    <= LEN_W'(0);
         accept_r  <= 1'b0;
         reject_r  <= 1'b0;
         pulse_r   <= 1'b0;
         count_r   <= CNT_W'(0);
      end else begin
         if (bus.cfg_wr && bus.cfg_ctrl) begin
            len_r     <= bus.cfg_len;
            mode_r    <= bus.cfg_mode;
            enabled_r <= (bus.cfg_len != LEN_W'(0)) && (int'(bus.cfg_len) <= MAX_LEN);
         end else if (bus.cfg_wr && (int'(bus.cfg_idx) < MAX_LEN)) begin
            pattern_r[bus.cfg_idx] <= bus.cfg_data;
         end
         if (shift_s) begin
            for (int i = 0; i < MAX_LEN; i++) begin
               win_r[i] <= win_s[i];
            end
         end
         state_r  <= state_n_s;
         pos_r    <= pos_n_s;
         fill_r   <= fill_n_s;
         accept_r <= accept_n_s;
         reject_r <= reject_n_s;
         pulse_r  <= pulse_n_s;
         if (bus.clr_count) begin
            count_r <= CNT_W'(0);
         end else if (pulse_n_s && (count_r != {CNT_W{1'b1}})) begin
            count_r <= count_r + CNT_W'(1);
         end
      end
   end

   assign bus.accept      = accept_r;
   assign bus.reject      = reject_r;
   assign bus.match_pulse = pulse_r;
   assign bus.match_count = count_r;
   assign bus.enabled     = enabled_r;
endmodule

// File: tb/tb_pattern_matcher.sv
// -----------------------------------------------------------------------------
// tb_pattern_matcher
// Directed scenarios followed by randomized traffic. Each cycle's expected
// status comes from a sequence-level reference model and is queued; a monitor
// pops and compares on every falling edge.
// -----------------------------------------------------------------------------
module tb_pattern_matcher;
   localparam int DATA_W  = 8;
   localparam int MAX_LEN = 5;
   localparam int CNT_W   = 2;
   localparam int IDX_W   = 3;
   localparam int LEN_W   = 3;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pattern_matcher_if #(.DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

   pattern_matcher #(.DATA_W(DATA_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic             acc;
      logic             rej;
      logic             pulse;
      logic             en;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   // reference model state
   logic [7:0] m_pat [MAX_LEN];
   int         m_len, m_cnt;
   logic       m_mode, m_acc, m_rej, m_pulse;
   logic [7:0] m_cur[$];    // symbols of the anchored attempt in progress
   logic [7:0] m_hist[$];   // most recent symbols in streaming mode
   logic [7:0] alpha [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] fold(input logic [7:0] b);
`ifdef PATTERN_MATCHER_CASE_FOLD_EN
      if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
      return b;
   endfunction

   task automatic model_step(input logic r, input logic wr, input logic ctrl, input int idx,
                             input logic [7:0] cdata, input int clen, input logic cmode,
                             input logic v, input logic [7:0] d, input logic clr);
      bit hit;
      int n;
      if (r) begin
         for (int i = 0; i < MAX_LEN; i++) m_pat[i] = 8'h00;
         m_len = 0; m_mode = 1'b0; m_acc = 1'b0; m_rej = 1'b0; m_pulse = 1'b0; m_cnt = 0;
         m_cur.delete(); m_hist.delete();
      end else begin
         m_pulse = 1'b0;
         if (wr) begin
            if (ctrl) begin
               m_len = clen; m_mode = cmode;
            end else if (idx < MAX_LEN) begin
               m_pat[idx] = cdata;
            end
            m_cur.delete(); m_hist.delete();
            m_acc = 1'b0; m_rej = 1'b0;
         end else if (v && m_len >= 1 && m_len <= MAX_LEN) begin
            if (m_mode) begin
               m_hist.push_back(d);
               if (m_hist.size() > MAX_LEN) void'(m_hist.pop_front());
               n   = m_hist.size();
               hit = (n >= m_len);
               for (int k = 0; k < m_len && hit; k++)
                  if (fold(m_hist[n - m_len + k]) != fold(m_pat[k])) hit = 1'b0;
               m_acc = hit; m_rej = 1'b0; m_pulse = hit;
            end else begin
               m_cur.push_back(d);
               n = m_cur.size();
               if (fold(d) == fold(m_pat[n-1])) begin
                  if (n == m_len) begin
                     m_acc = 1'b1; m_rej = 1'b0; m_pulse = 1'b1; m_cur.delete();
                  end else begin
                     m_acc = 1'b0; m_rej = 1'b0;
                  end
               end else begin
                  m_acc = 1'b0; m_rej = 1'b1; m_cur.delete();
               end
            end
         end
         if (clr) m_cnt = 0;
         else if (m_pulse && m_cnt < CNT_MAX) m_cnt++;
      end
   endtask

   // one clock of stimulus; expectation queued just after the edge it applies to
   task automatic cycle(input logic r, input logic wr, input logic ctrl, input int idx,
                        input logic [7:0] cdata, input int clen, input logic cmode,
                        input logic v, input logic [7:0] d, input logic clr);
      exp_t e;
      @(negedge clk);
      rst            = r;
      bus.cfg_wr     = wr;
      bus.cfg_ctrl   = ctrl;
      bus.cfg_idx    = IDX_W'(idx);
      bus.cfg_data   = cdata;
      bus.cfg_len    = LEN_W'(clen);
      bus.cfg_mode   = cmode;
      bus.data_valid = v;
      bus.data_in    = d;
      bus.clr_count  = clr;
      @(posedge clk);
      #1;
      model_step(r, wr, ctrl, idx, cdata, clen, cmode, v, d, clr);
      e.acc = m_acc; e.rej = m_rej; e.pulse = m_pulse;
      e.en  = (m_len >= 1 && m_len <= MAX_LEN);
      e.cnt = CNT_W'(m_cnt);
      sb_q.push_back(e);
   endtask

   task automatic sym(input logic [7:0] d);
      cycle(1'b0, 1'b0, 1'b0, 0, 8'h00, 0, 1'b0, 1'b1, d, 1'b0);
   endtask
   task automatic wr_pat(input int i, input logic [7:0] d);
      cycle(1'b0, 1'b1, 1'b0, i, d, 0, 1'b0, 1'b0, 8'h00, 1'b0);
   endtask
   task automatic wr_ctl(input int l, input logic m);
      cycle(1'b0, 1'b1, 1'b1, 0, 8'h00, l, m, 1'b0, 8'h00, 1'b0);
   endtask
   task automatic clear_cnt();
      cycle(1'b0, 1'b0, 1'b0, 0, 8'h00, 0, 1'b0, 1'b0, 8'h00, 1'b1);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("accept",      32'(bus.accept),      32'(e.acc));
         chk("reject",      32'(bus.reject),      32'(e.rej));
         chk("match_pulse", 32'(bus.match_pulse), 32'(e.pulse));
         chk("match_count", 32'(bus.match_count), 32'(e.cnt));
         chk("enabled",     32'(bus.enabled),     32'(e.en));
      end
   end

   initial begin
      alpha[0] = 8'h41; alpha[1] = 8'h42; alpha[2] = 8'h61; alpha[3] = 8'h62; alpha[4] = 8'h43;
      bus.cfg_wr = 1'b0; bus.cfg_ctrl = 1'b0; bus.cfg_idx = '0; bus.cfg_data = '0;
      bus.cfg_len = '0; bus.cfg_mode = 1'b0; bus.data_valid = 1'b0; bus.data_in = '0;
      bus.clr_count = 1'b0;

      cycle(1'b1, 1'b0, 1'b0, 0, 8'h00, 0, 1'b0, 1'b0, 8'h00, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 0, 8'h00, 0, 1'b0, 1'b1, 8'h41, 1'b0);
      chk("rst_enabled", 32'(bus.enabled), 32'd0);
      chk("rst_count",   32'(bus.match_count), 32'd0);
      sym(8'h00);   // disabled: len 0, even a symbol equal to pattern[0] is ignored
      chk("disabled_accept", 32'(bus.accept), 32'd0);

      // anchored "CAT"
      wr_pat(0, 8'h43); wr_pat(1, 8'h41); wr_pat(2, 8'h54); wr_ctl(3, 1'b0);
      sym(8'h43); sym(8'h41); sym(8'h54);
      chk("cat_accept", 32'(bus.accept), 32'd1);
      chk("cat_count",  32'(bus.match_count), 32'd1);
      // C,X,A,T -> reject held
      sym(8'h43); sym(8'h58);
      chk("cxat_rej_x", 32'(bus.reject), 32'd1);
      sym(8'h41); sym(8'h54);
      chk("cxat_rej_t", 32'(bus.reject), 32'd1);
      chk("cxat_count", 32'(bus.match_count), 32'd1);

      // reconfiguration mid-sequence, symbol in the cfg_wr cycle dropped
      sym(8'h43); sym(8'h41);
      cycle(1'b0, 1'b1, 1'b1, 0, 8'h00, 2, 1'b0, 1'b1, 8'h54, 1'b0);
      chk("reconf_flush", 32'(bus.accept), 32'd0);
      sym(8'h43); sym(8'h41);
      chk("reconf_accept", 32'(bus.accept), 32'd1);

      // case fold
      wr_ctl(3, 1'b0);
      sym(8'h63);
`ifdef PATTERN_MATCHER_CASE_FOLD_EN
      sym(8'h61); sym(8'h74);
      chk("fold_accept", 32'(bus.accept), 32'd1);
`else
      chk("nofold_reject", 32'(bus.reject), 32'd1);
`endif

      // streaming "ABA" on A,B,A,B,A
      clear_cnt();
      wr_pat(0, 8'h41); wr_pat(1, 8'h42); wr_pat(2, 8'h41); wr_ctl(3, 1'b1);
      sym(8'h41); sym(8'h42); sym(8'h41);
      chk("aba_pulse3", 32'(bus.match_pulse), 32'd1);
      sym(8'h42); sym(8'h41);
      chk("aba_count", 32'(bus.match_count), 32'd2);

      // out-of-range index write ignored but still flushes
      wr_pat(6, 8'h5A);
      chk("oob_flush", 32'(bus.accept), 32'd0);

      // saturating counter with 'Z'
      clear_cnt();
      wr_pat(0, 8'h5A); wr_ctl(1, 1'b1);
      for (int i = 1; i <= 5; i++) begin
         sym(8'h5A);
         chk("sat_count", 32'(bus.match_count), 32'((i > CNT_MAX) ? CNT_MAX : i));
      end
      cycle(1'b0, 1'b0, 1'b0, 0, 8'h00, 0, 1'b0, 1'b1, 8'h5A, 1'b1);
      chk("clr_priority", 32'(bus.match_count), 32'd0);
      wr_ctl(7, 1'b0);
      chk("len7_disabled", 32'(bus.enabled), 32'd0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         logic r, wr, ctrl, m, v, clr;
         int   idx, l;
         r    = ($urandom_range(0, 499) == 0);
         wr   = ($urandom_range(0, 39) == 0);
         ctrl = $urandom_range(0, 1);
         idx  = $urandom_range(0, 7);
         l    = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : $urandom_range(1, MAX_LEN);
         m    = $urandom_range(0, 1);
         v    = ($urandom_range(0, 3) != 0);
         clr  = ($urandom_range(0, 59) == 0);
         cycle(r, wr, ctrl, idx, alpha[$urandom_range(0, 4)], l, m, v,
               alpha[$urandom_range(0, 4)], clr);
      end
      cycle(1'b0, 1'b0, 1'b0, 0, 8'h00, 0, 1'b0, 1'b0, 8'h00, 1'b0);
      @(negedge clk);
      #1;
      chk("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
